// File: rtl/vga_mux_pkg.sv
// vga_mux_pkg: shared fade states, colour constants and RGB332 to 24-bit expansion.
package vga_mux_pkg;
   localparam int COLOR_W = 8;
   localparam int FADE_FULL = 8;
   typedef enum logic [1:0] {SHOWN, FADE_OUT, DARK, FADE_IN} fade_state_t;
   // Each field is widened by replicating its LSB, so full-scale stays full-scale.
   function automatic logic [23:0] rgb332_expand(input logic [7:0] p);
      return {p[7:5], {5{p[5]}}, p[4:2], {5{p[2]}}, p[1:0], {6{p[0]}}};
   endfunction
endpackage

// File: rtl/vga_fade_ctrl.sv
// vga_fade_ctrl: per-frame brightness ramp between SHOWN and DARK with reversible fades.
module vga_fade_ctrl #(
   parameter int FADE_FULL = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       fade_out_req,
   input  logic       fade_in_req,
   output logic [3:0] fade_level,
   output logic       fade_busy,
   output logic       fade_done
);
   import vga_mux_pkg::*;
   localparam logic [3:0] FULL = 4'(FADE_FULL);
   fade_state_t state, state_nxt;
   logic [3:0] level_nxt;
   logic done_nxt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= SHOWN;
         fade_level <= FULL;
         fade_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         fade_level <= level_nxt;
         fade_done  <= done_nxt;
      end
   // A state-changing request takes the cycle; frame_tick only moves the level otherwise.
   always_comb begin
      state_nxt = state;
      level_nxt = fade_level;
      done_nxt  = 1'b0;
      case (state)
         SHOWN: if (fade_out_req) state_nxt = FADE_OUT;
         DARK:  if (fade_in_req && !fade_out_req) state_nxt = FADE_IN;
         FADE_OUT:
            if (fade_in_req && !fade_out_req) state_nxt = FADE_IN;
            else if (frame_tick) begin
               level_nxt = (fade_level == 4'd0) ? 4'd0 : fade_level - 4'd1;
               if (level_nxt == 4'd0) begin
                  state_nxt = DARK;
                  done_nxt  = 1'b1;
               end
            end
         default:
            if (fade_out_req) state_nxt = FADE_OUT;
            else if (frame_tick) begin
               level_nxt = (fade_level >= FULL) ? FULL : fade_level + 4'd1;
               if (level_nxt == FULL) begin
                  state_nxt = SHOWN;
                  done_nxt  = 1'b1;
               end
            end
      endcase
   end
   assign fade_busy = (state == FADE_OUT) || (state == FADE_IN);
endmodule

// File: rtl/vga_layer_mux_fader.sv
// vga_layer_mux_fader: priority layer select, RGB332 expansion and fade scaling in a 2-stage pipe.
module vga_layer_mux_fader #(
   parameter int NUM_LAYERS = 10,
   parameter int COLOR_W    = 8,
   parameter int FADE_FULL  = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               frame_tick,
   input  logic [NUM_LAYERS-1:0]              draw_req,
   input  logic [NUM_LAYERS-1:0][COLOR_W-1:0] layer_rgb,
   input  logic [NUM_LAYERS-1:0]              layer_en,
   input  logic [COLOR_W-1:0]                 background_rgb,
   input  logic                               fade_out_req,
   input  logic                               fade_in_req,
   output logic [7:0]                         red_out,
   output logic [7:0]                         green_out,
   output logic [7:0]                         blue_out,
   output logic [3:0]                         fade_level,
   output logic                               fade_busy,
   output logic                               fade_done
);
   import vga_mux_pkg::*;
   logic [COLOR_W-1:0] sel, pix1;
   logic [23:0] rgb;
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] l);
      return 8'(({4'b0, c} * {8'b0, l}) >> 3);
   endfunction
   vga_fade_ctrl #(.FADE_FULL(FADE_FULL)) u_fade (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
      .fade_level(fade_level), .fade_busy(fade_busy), .fade_done(fade_done)
   );
   // Scan from lowest priority upward so the lowest requesting index lands last.
   always_comb begin
      sel = background_rgb;
      for (int i = NUM_LAYERS - 1; i >= 0; i--)
         if (draw_req[i] && layer_en[i]) sel = layer_rgb[i];
   end
   assign rgb = rgb332_expand(pix1);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pix1      <= '0;
         red_out   <= '0;
         green_out <= '0;
         blue_out  <= '0;
      end else begin
         pix1      <= sel;
         red_out   <= scale(rgb[23:16], fade_level);
         green_out <= scale(rgb[15:8], fade_level);
         blue_out  <= scale(rgb[7:0], fade_level);
      end
endmodule
